// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS MEM/WB stage
package mips_pkg;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } mem_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] RA       = 5'd31;

    typedef struct packed {
        logic ifWriteRegsFile;
        logic ifWriteMem;
        logic memOutOrAluOut;
    } pipe_ctrl_t;

    // True when an instruction with these control bits really changes a register
    function automatic logic writes_reg(input pipe_ctrl_t ctrl, input logic [4:0] rd);
        return ctrl.ifWriteRegsFile && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - data-memory bus with ready handshake
interface mem_wb_stage_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        MIO_ready;

    modport master (
        output mem_addr, mem_wdata, mem_req, mem_we,
        input  mem_rdata, MIO_ready
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_req, mem_we,
        output mem_rdata, MIO_ready
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory access FSM, wait counter, stall/request (MEM_TIMEOUT_EN adds timeout)
module mem_access_ctrl
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic m_valid,
    input  logic memop,
    input  logic MIO_ready,
    output logic mem_req,
    output logic memStall,
    output logic bus_error
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_params
        $error("mem_access_ctrl: CNT_W cannot hold TIMEOUT_CYCLES");
    end

    mem_state_e state_q;

`ifdef MEM_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
`endif

    // Track outstanding access; with the timeout build, give up into a sticky error state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_RUN;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_RUN: begin
                    if (memop && !MIO_ready) begin
                        state_q <= S_WAIT;
`ifdef MEM_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (MIO_ready) begin
                        state_q <= S_RUN;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (cnt_q == CNT_LAST) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
`endif
                end
                S_ERR:   state_q <= S_ERR;
                default: state_q <= S_RUN;
            endcase
        end
    end

    // A dead bus keeps the instruction in MEM forever and stops requesting
    assign memStall = (memop & ~MIO_ready) | (m_valid & (state_q == S_ERR));
    assign mem_req  = memop & (state_q != S_ERR);

`ifdef MEM_TIMEOUT_EN
    assign bus_error = err_q;
`else
    assign bus_error = 1'b0;
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MIPS MEM and WB stages with EX/MEM and MEM/WB registers (optional MEM_TIMEOUT_EN)
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [31:0]           ex_aluOut,
    input  logic [31:0]           ex_storeData,
    input  logic [4:0]            ex_registerWriteAddress,
    input  logic                  ex_ifWriteRegsFile,
    input  logic                  ex_ifWriteMem,
    input  logic                  ex_memOutOrAluOut,
    mem_wb_stage_if.master        dbus,
    output logic                  memStall,
    output logic                  mem_shouldWriteRegister,
    output logic [4:0]            mem_registerWriteAddress,
    output logic                  wb_RegWrite,
    output logic [4:0]            wb_writeRegAddr,
    output logic [31:0]           wb_writeRegData,
    output logic                  bus_error
);

    pipe_ctrl_t  ex_ctrl;
    assign ex_ctrl = '{ifWriteRegsFile: ex_ifWriteRegsFile,
                       ifWriteMem:      ex_ifWriteMem,
                       memOutOrAluOut:  ex_memOutOrAluOut};

    logic        m_valid_q, m_valid_d;
    logic [31:0] m_alu_q,   m_alu_d;
    logic [31:0] m_sd_q,    m_sd_d;
    logic [4:0]  m_rd_q,    m_rd_d;
    pipe_ctrl_t  m_ctrl_q,  m_ctrl_d;

    logic        w_valid_q, w_valid_d;
    logic        w_we_q,    w_we_d;
    logic [4:0]  w_addr_q,  w_addr_d;
    logic [31:0] w_data_q,  w_data_d;

    logic        m_load, m_store, memop, retire, mem_req_w;

    assign m_load  = m_ctrl_q.memOutOrAluOut;
    assign m_store = m_ctrl_q.ifWriteMem;
    assign memop   = m_valid_q & (m_load | m_store);
    assign retire  = m_valid_q & ~memStall;

    mem_access_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .m_valid   (m_valid_q),
        .memop     (memop),
        .MIO_ready (dbus.MIO_ready),
        .mem_req   (mem_req_w),
        .memStall  (memStall),
        .bus_error (bus_error)
    );

    // EX/MEM advances only when MEM is not stalled; MEM/WB takes a bubble while stalled
    always_comb begin
        m_valid_d = m_valid_q;
        m_alu_d   = m_alu_q;
        m_sd_d    = m_sd_q;
        m_rd_d    = m_rd_q;
        m_ctrl_d  = m_ctrl_q;
        if (!memStall) begin
            m_valid_d = ex_valid;
            m_alu_d   = ex_aluOut;
            m_sd_d    = ex_storeData;
            m_rd_d    = ex_registerWriteAddress;
            m_ctrl_d  = ex_ctrl;
        end

        w_valid_d = m_valid_q & ~memStall;
        w_we_d    = w_we_q;
        w_addr_d  = w_addr_q;
        w_data_d  = w_data_q;
        if (retire) begin
            w_we_d   = m_ctrl_q.ifWriteRegsFile;
            w_addr_d = m_rd_q;
            w_data_d = m_load ? dbus.mem_rdata : m_alu_q;
        end
    end

    // Pipeline registers; reset empties both stages
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_valid_q <= 1'b0;
            m_alu_q   <= '0;
            m_sd_q    <= '0;
            m_rd_q    <= '0;
            m_ctrl_q  <= '0;
            w_valid_q <= 1'b0;
            w_we_q    <= 1'b0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_alu_q   <= m_alu_d;
            m_sd_q    <= m_sd_d;
            m_rd_q    <= m_rd_d;
            m_ctrl_q  <= m_ctrl_d;
            w_valid_q <= w_valid_d;
            w_we_q    <= w_we_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
        end
    end

    assign dbus.mem_req   = mem_req_w;
    assign dbus.mem_we    = m_valid_q & m_store;
    assign dbus.mem_addr  = memop ? m_alu_q : 32'd0;
    assign dbus.mem_wdata = memop ? m_sd_q  : 32'd0;

    assign mem_shouldWriteRegister  = m_valid_q & writes_reg(m_ctrl_q, m_rd_q);
    assign mem_registerWriteAddress = m_valid_q ? m_rd_q : REG_ZERO;

    assign wb_RegWrite     = w_valid_q & w_we_q & (w_addr_q != REG_ZERO);
    assign wb_writeRegAddr = w_valid_q ? w_addr_q : REG_ZERO;
    assign wb_writeRegData = w_valid_q ? w_data_q : 32'd0;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_aluOut;
    logic [31:0] ex_storeData;
    logic [4:0]  ex_registerWriteAddress;
    logic        ex_ifWriteRegsFile;
    logic        ex_ifWriteMem;
    logic        ex_memOutOrAluOut;
    logic        memStall;
    logic        mem_shouldWriteRegister;
    logic [4:0]  mem_registerWriteAddress;
    logic        wb_RegWrite;
    logic [4:0]  wb_writeRegAddr;
    logic [31:0] wb_writeRegData;
    logic        bus_error;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_wb_stage_if dbus ();

    mem_wb_stage #(.TIMEOUT_CYCLES(4), .CNT_W(5)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .ex_valid                 (ex_valid),
        .ex_aluOut                (ex_aluOut),
        .ex_storeData             (ex_storeData),
        .ex_registerWriteAddress  (ex_registerWriteAddress),
        .ex_ifWriteRegsFile       (ex_ifWriteRegsFile),
        .ex_ifWriteMem            (ex_ifWriteMem),
        .ex_memOutOrAluOut        (ex_memOutOrAluOut),
        .dbus                     (dbus),
        .memStall                 (memStall),
        .mem_shouldWriteRegister  (mem_shouldWriteRegister),
        .mem_registerWriteAddress (mem_registerWriteAddress),
        .wb_RegWrite              (wb_RegWrite),
        .wb_writeRegAddr          (wb_writeRegAddr),
        .wb_writeRegData          (wb_writeRegData),
        .bus_error                (bus_error)
    );

    typedef struct {
        bit          v;
        bit          ld;
        bit          st;
        bit          wr;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] res;
    } instr_t;

    function automatic instr_t mk(bit v, bit ld, bit st, bit wr, logic [4:0] rd,
                                  logic [31:0] alu, logic [31:0] sd);
        instr_t i;
        i.v = v; i.ld = ld; i.st = st; i.wr = wr; i.rd = rd;
        i.alu = alu; i.sd = sd; i.res = 32'd0;
        return i;
    endfunction

    task automatic drive(input instr_t i);
        ex_valid                = i.v;
        ex_aluOut               = i.alu;
        ex_storeData            = i.sd;
        ex_registerWriteAddress = i.rd;
        ex_ifWriteRegsFile      = i.wr;
        ex_ifWriteMem           = i.st;
        ex_memOutOrAluOut       = i.ld;
    endtask

    task automatic bubble();
        drive(mk(0, 0, 0, 0, 5'd0, 32'd0, 32'd0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [111:0] got;
        rst = 1'b0;
        drive(mk(1, 0, 0, 1, 5'd9, 32'h99, 32'h0));
        dbus.MIO_ready = 1'b0;
        dbus.mem_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        @(negedge clk);
        got = {memStall, dbus.mem_req, dbus.mem_we, dbus.mem_addr, dbus.mem_wdata,
               mem_shouldWriteRegister, mem_registerWriteAddress,
               wb_RegWrite, wb_writeRegAddr, wb_writeRegData, bus_error};
        n_checks++;
        if (got !== 112'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", got);
        end
        tick();
        rst = 1'b1;
        bubble();
        dbus.MIO_ready = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        drive(mk(1, 0, 0, 1, 5'd3, 32'h5, 32'h0));
        dbus.MIO_ready = 1'b1;
        tick();
        bubble();
        @(negedge clk);
        n_checks++;
        if ({mem_shouldWriteRegister, mem_registerWriteAddress, memStall, dbus.mem_req, wb_RegWrite}
            !== {1'b1, 5'd3, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL alu_in_mem: got shw=%b rd=%0d stall=%b req=%b wbwe=%b want 1 3 0 0 0",
                     mem_shouldWriteRegister, mem_registerWriteAddress, memStall, dbus.mem_req, wb_RegWrite);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({wb_RegWrite, wb_writeRegAddr, wb_writeRegData} !== {1'b1, 5'd3, 32'h5}) begin
            n_fail++;
            $display("FAIL alu_wb: got we=%b addr=%0d data=%h want 1 3 5",
                     wb_RegWrite, wb_writeRegAddr, wb_writeRegData);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (wb_RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_wb_single_pulse: got %b want 0", wb_RegWrite);
        end
        tick();
    endtask

    task automatic test_load_stall();
        int stalls = 0;
        drive(mk(1, 1, 0, 1, 5'd4, 32'h10, 32'h0));
        dbus.MIO_ready = 1'b0;
        tick();
        bubble();
        for (int i = 0; i < 3; i++) begin
            dbus.MIO_ready = 1'b0;
            dbus.mem_rdata = 32'h0BAD_0000 + i;
            @(negedge clk);
            if (memStall === 1'b1) stalls++;
            n_checks++;
            if ({dbus.mem_req, dbus.mem_we, dbus.mem_addr, wb_RegWrite} !== {1'b1, 1'b0, 32'h10, 1'b0}) begin
                n_fail++;
                $display("FAIL load_wait_bus: got req=%b we=%b addr=%h wbwe=%b want 1 0 10 0",
                         dbus.mem_req, dbus.mem_we, dbus.mem_addr, wb_RegWrite);
            end
            tick();
        end
        dbus.MIO_ready = 1'b1;
        dbus.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        if (memStall === 1'b1) stalls++;
        n_checks++;
        if (stalls != 3) begin
            n_fail++;
            $display("FAIL load_stall_cycles: got %0d want 3", stalls);
        end
        tick();
        dbus.MIO_ready = 1'b0;
        dbus.mem_rdata = 32'h0;
        @(negedge clk);
        n_checks++;
        if ({wb_RegWrite, wb_writeRegAddr, wb_writeRegData, memStall} !== {1'b1, 5'd4, 32'hDEADBEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL load_wb: got we=%b addr=%0d data=%h stall=%b want 1 4 deadbeef 0",
                     wb_RegWrite, wb_writeRegAddr, wb_writeRegData, memStall);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (wb_RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL load_wb_single_pulse: got %b want 0", wb_RegWrite);
        end
        tick();
    endtask

    task automatic test_store();
        drive(mk(1, 0, 1, 0, 5'd5, 32'h20, 32'h1234));
        dbus.MIO_ready = 1'b1;
        tick();
        bubble();
        @(negedge clk);
        n_checks++;
        if ({dbus.mem_req, dbus.mem_we, dbus.mem_addr, dbus.mem_wdata, memStall, mem_shouldWriteRegister}
            !== {1'b1, 1'b1, 32'h20, 32'h1234, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL store_bus: got req=%b we=%b addr=%h wdata=%h stall=%b shw=%b want 1 1 20 1234 0 0",
                     dbus.mem_req, dbus.mem_we, dbus.mem_addr, dbus.mem_wdata, memStall, mem_shouldWriteRegister);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({dbus.mem_req, dbus.mem_we, wb_RegWrite} !== 3'b000) begin
            n_fail++;
            $display("FAIL store_after: got req=%b we=%b wbwe=%b want 0 0 0",
                     dbus.mem_req, dbus.mem_we, wb_RegWrite);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        int bad = 0;
        drive(mk(1, 0, 0, 1, 5'd0, 32'h7, 32'h0));
        dbus.MIO_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            bubble();
            @(negedge clk);
            if (mem_shouldWriteRegister !== 1'b0 || wb_RegWrite !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL zero_reg_write: got %0d cycles with a write indication want 0", bad);
        end
        tick();
    endtask

    task automatic test_reset_in_stall();
        int writes = 0;
        drive(mk(1, 1, 0, 1, 5'd6, 32'h30, 32'h0));
        dbus.MIO_ready = 1'b0;
        tick();
        bubble();
        @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({memStall, dbus.mem_req} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_stall_before: got stall=%b req=%b want 1 1", memStall, dbus.mem_req);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({dbus.mem_req, memStall, wb_RegWrite} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_stall_after: got req=%b stall=%b wbwe=%b want 0 0 0",
                     dbus.mem_req, memStall, wb_RegWrite);
        end
        dbus.MIO_ready = 1'b1;
        dbus.mem_rdata = 32'h5555_AAAA;
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            if (wb_RegWrite !== 1'b0) writes++;
        end
        n_checks++;
        if (writes != 0) begin
            n_fail++;
            $display("FAIL rst_stall_no_wb: got %0d write-backs want 0", writes);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        instr_t q[$];
        instr_t mm, mw, cur, nxt;
        logic [111:0] got, exp;
        logic [31:0]  rdata;
        bit           rdy, memop, stall;
        int consec = 0, cyc = 0, exp_pulses = 0, got_pulses = 0, errs = 0;

        for (int n = 0; n < 150; n++) begin
            int k;
            k = $urandom % 3;
            nxt = mk(($urandom % 5) != 0, k == 1, k == 2, 1'b0,
                     (($urandom % 6) == 0) ? 5'd0 : 5'($urandom),
                     $urandom, $urandom);
            nxt.wr = nxt.st ? bit'($urandom % 2) : (($urandom % 8) != 0);
            if (nxt.v && nxt.wr && nxt.rd != 5'd0) exp_pulses++;
            q.push_back(nxt);
        end

        mm = mk(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
        mw = mm;
        while ((q.size() > 0 || mm.v) && cyc < 3000) begin
            cur = (q.size() > 0) ? q[0] : mk(0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
            rdy = (consec >= 3) ? 1'b1 : (($urandom % 3) != 0);
            consec = rdy ? 0 : consec + 1;
            rdata = $urandom;
            drive(cur);
            dbus.MIO_ready = rdy;
            dbus.mem_rdata = rdata;

            memop = mm.v && (mm.ld || mm.st);
            stall = memop && !rdy;
            exp = {stall, memop, mm.v && mm.st,
                   memop ? mm.alu : 32'd0, memop ? mm.sd : 32'd0,
                   mm.v && mm.wr && (mm.rd != 5'd0), mm.v ? mm.rd : 5'd0,
                   mw.v && mw.wr && (mw.rd != 5'd0), mw.v ? mw.rd : 5'd0,
                   mw.v ? mw.res : 32'd0, 1'b0};

            @(negedge clk);
            got = {memStall, dbus.mem_req, dbus.mem_we, dbus.mem_addr, dbus.mem_wdata,
                   mem_shouldWriteRegister, mem_registerWriteAddress,
                   wb_RegWrite, wb_writeRegAddr, wb_writeRegData, bus_error};
            if (wb_RegWrite === 1'b1) got_pulses++;
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                errs++;
                if (errs <= 5)
                    $display("FAIL rand_outputs cycle %0d: got %h want %h", cyc, got, exp);
            end
            tick();

            if (!stall) begin
                mw     = mm;
                mw.res = mm.ld ? rdata : mm.alu;
                mm     = cur;
                if (q.size() > 0) void'(q.pop_front());
            end else begin
                mw.v = 1'b0;
            end
            cyc++;
        end

        bubble();
        dbus.MIO_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (wb_RegWrite === 1'b1) got_pulses++;
            tick();
        end
        n_checks++;
        if (cyc >= 3000) begin
            n_fail++;
            $display("FAIL rand_cycle_budget: got %0d cycles want < 3000", cyc);
        end
        n_checks++;
        if (got_pulses != exp_pulses) begin
            n_fail++;
            $display("FAIL rand_wb_pulses: got %0d want %0d", got_pulses, exp_pulses);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int bad = 0;
        drive(mk(1, 1, 0, 1, 5'd7, 32'h40, 32'h0));
        dbus.MIO_ready = 1'b0;
        tick();
        bubble();
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if ({bus_error, dbus.mem_req, memStall} !== {c >= 6, c < 6, 1'b1}) begin
                bad++;
                $display("FAIL timeout_cycle_%0d: got err=%b req=%b stall=%b want %b %b 1",
                         c, bus_error, dbus.mem_req, memStall, c >= 6, c < 6);
            end
            tick();
        end
        n_checks++;
        if (bad != 0) n_fail++;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus_error, memStall} !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_reset_clears: got err=%b stall=%b want 0 0", bus_error, memStall);
        end
        tick();
    endtask
`endif

    initial begin
        rst = 1'b0;
        bubble();
        dbus.MIO_ready = 1'b0;
        dbus.mem_rdata = 32'd0;
        test_reset();
        test_alu();
        test_load_stall();
        test_store();
        test_zero_reg();
        test_reset_in_stall();
        test_back_to_back();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM and WB stages of the 5-stage pipelined MIPS CPU.
- Holds the EX/MEM and MEM/WB pipeline registers and drives the data-memory bus with a ready handshake.
- Produces the register-file write-back (`wb_RegWrite`, `wb_writeRegAddr`, `wb_writeRegData`) consumed by the ID stage.
- Also produces the MEM-stage hazard info (`mem_shouldWriteRegister`, `mem_registerWriteAddress`) used by ID stall logic.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles to wait for MIO_ready (only used with MEM_TIMEOUT_EN).
- CNT_W, 5: width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset; synchronous, active-low (0 = reset)
- ex_valid  input  1  EX holds a real instruction (0 = bubble)
- ex_aluOut  input  32  ALU result / memory address
- ex_storeData  input  32  rt value for SW
- ex_registerWriteAddress  input  5  destination register
- ex_ifWriteRegsFile  input  1  instruction writes the register file
- ex_ifWriteMem  input  1  store
- ex_memOutOrAluOut  input  1  1 = load (write back memory data)
- mem_addr  output  32  data-memory address
- mem_wdata  output  32  store data
- mem_req  output  1  memory access request
- mem_we  output  1  write enable, valid with mem_req
- mem_rdata  input  32  load data, valid when MIO_ready=1
- MIO_ready  input  1  memory completes the access this cycle
- memStall  output  1  freeze PC/IF/ID/EX this cycle
- mem_shouldWriteRegister  output  1  MEM-stage instruction will write a register
- mem_registerWriteAddress  output  5  its destination
- wb_RegWrite  output  1  register-file write strobe
- wb_writeRegAddr  output  5  write address
- wb_writeRegData  output  32  write data
- bus_error  output  1  sticky timeout flag (0 when feature is compiled out)

Behaviour:
- **Reset (rst=0 at an edge):** both valid bits cleared, FSM to S_RUN, wait counter 0, bus_error 0.
  - Reset during S_WAIT abandons the access; mem_req is 0 from the next cycle.
- **Output values while valid bits are 0:** all outputs are combinational from registers, so every output reads 0.
- **EX/MEM register:** loads all ex_* inputs plus ex_valid at each edge when memStall=0; holds when memStall=1.
- **memop** = m_valid & (m_load | m_store).
  - mem_req = memop.
  - mem_we = m_valid & m_store.
  - mem_addr = m_aluOut; mem_wdata = m_storeData.
  - mem_addr and mem_wdata are 0 when memop=0.
- **memStall** = memop & ~MIO_ready (combinational). It is also forced to 1 in S_ERR while m_valid.
- **FSM:**
  - S_RUN: memop & ~MIO_ready -> S_WAIT, counter cleared.
  - S_WAIT: counter increments each cycle. MIO_ready -> S_RUN.
  - Timeout path (only with MEM_TIMEOUT_EN): counter == TIMEOUT_CYCLES-1 with no ready -> S_ERR.
- **Retire:** an instruction retires at the edge where m_valid & ~memStall. At that edge the MEM/WB register captures:
  - w_valid = m_valid;
  - w_addr = m_registerWriteAddress;
  - w_data = m_load ? mem_rdata : m_aluOut;
  - w_we = m_ifWriteRegsFile.
- **Bubble insertion:** when memStall=1, the MEM/WB register loads a bubble (w_valid=0). A retirement therefore yields exactly one wb_RegWrite pulse.
- **Write-back outputs:**
  - wb_RegWrite = w_valid & w_we & (w_addr != 0).
  - wb_writeRegAddr = w_addr; wb_writeRegData = w_data.
- **Hazard outputs:**
  - mem_shouldWriteRegister = m_valid & m_ifWriteRegsFile & (m_registerWriteAddress != 0).
  - mem_registerWriteAddress = m_registerWriteAddress.
- **Latency:**
  - ALU op: EX->MEM edge N, retire edge N+1, wb_* visible in cycle N+1.
  - Memory op with MIO_ready first seen in cycle k after entering MEM: retires at edge N+1+k.
- **Store-and-write simultaneously:** a store with ex_ifWriteRegsFile=1 performs both actions.
- **mem_rdata:** sampled only on the retiring edge of a load; ignored otherwise.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- **Defined:**
  - The S_WAIT counter is active.
  - Reaching TIMEOUT_CYCLES without MIO_ready sets bus_error=1 (sticky until reset).
  - The FSM enters S_ERR, drops mem_req, and holds memStall=1 permanently.
- **Undefined:**
  - No counter and no S_ERR; S_WAIT waits indefinitely.
  - bus_error tied 0.

Decomposition:
- **Shared package mips_pkg:**
  - FSM state encoding (S_RUN, S_WAIT, S_ERR);
  - REG_ZERO = 5'd0 and RA = 5'd31;
  - a struct/bundle for pipeline control bits (ifWriteRegsFile, ifWriteMem, memOutOrAluOut).
- **One sub-module, mem_access_ctrl:** the FSM, wait counter and memStall/mem_req generation. Pipeline registers stay in mem_wb_stage.

Test Plan:
- ADD $3 (ex_aluOut=32'h5, addr 3, regwrite) with no stall -> one-cycle wb_RegWrite=1, wb_writeRegAddr=3, wb_writeRegData=5, one cycle after MEM entry.
- LW to $4, addr 32'h10, MIO_ready low 3 cycles then high with mem_rdata=32'hDEADBEEF:
  - memStall=1 for exactly 3 cycles and mem_req held high;
  - wb shows addr 4, data DEADBEEF once.
- SW addr 32'h20, data 32'h1234, MIO_ready=1 immediately -> mem_req=1, mem_we=1 for one cycle, no wb_RegWrite, no stall.
- ADDI to $0 -> mem_shouldWriteRegister=0 and wb_RegWrite=0 throughout.
- rst=0 asserted in the 2nd stall cycle of a load -> next cycle mem_req=0, memStall=0, wb_RegWrite=0; no write-back after release.
- (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4) load with MIO_ready stuck 0 -> bus_error=1 after the 4th wait cycle, memStall stays 1, mem_req=0.
